pc_ir_unit: RTL and testbench

Program-counter and instruction-register datapath stage for the multicycle MIPS core. It sits directly downstream of the multicycle control FSM and consumes its PC_Write, Branch, PC_Src and IR_Write strobes. It holds PC, IR and the ALU output register, selects and commits the next PC, and feeds the decoded Op/Funct fields back to the FSM. It also keeps a retired-instruction counter and a sticky misaligned-PC fault flag.

---
 rtl/pc_ir_unit.sv | 121 ++++++++++++
 tb/tb_pc_ir_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_unit.sv
// PC / IR / ALU-output register stage of the multicycle MIPS core: selects and
// commits the next PC, latches instructions, counts retirements and flags misaligned targets.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PC_Write,
    input  logic             Branch,
    input  logic [1:0]       PC_Src,
    input  logic             IR_Write,
    input  logic             zero,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      reg_a,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      inst_pc,
    output logic [31:0]      ir,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm,
    output logic [31:0]      alu_out,
    output logic [CNT_W-1:0] instr_count,
    output logic             pc_fault
);

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_JR     = 2'b11
    } pc_src_e;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      alu_out_q;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             pc_fault_q, pc_fault_d;

    logic [31:0]      next_pc;
    logic             pc_en;
    logic             misaligned;

    // Next-PC select; the jump target keeps the current PC's region bits.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_pc = alu_result;
        unique case (pc_src_e'(PC_Src))
            SRC_SEQ:    next_pc = alu_result;
            SRC_BRANCH: next_pc = alu_out_q;
            SRC_JUMP:   next_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
            SRC_JR:     next_pc = reg_a;
            default:    next_pc = alu_result;
        endcase
    end

    assign pc_en      = PC_Write | (Branch & zero);
    assign misaligned = (next_pc[1:0] != 2'b00);

    always_comb begin
        pc_d          = pc_q;
        pc_fault_d    = pc_fault_q;
        ir_d          = ir_q;
        inst_pc_d     = inst_pc_q;
        instr_count_d = instr_count_q;

        // A misaligned target is dropped and recorded; the fault stays until reset.
        if (pc_en) begin
            if (misaligned) begin
                pc_fault_d = 1'b1;
            end else begin
                pc_d = next_pc;
            end
        end

        if (IR_Write) begin
            ir_d          = mem_rdata;
            inst_pc_d     = pc_q;
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inst_pc_q     <= '0;
            ir_q          <= '0;
            alu_out_q     <= '0;
            instr_count_q <= '0;
            pc_fault_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inst_pc_q     <= inst_pc_d;
            ir_q          <= ir_d;
            alu_out_q     <= alu_result;
            instr_count_q <= instr_count_d;
            pc_fault_q    <= pc_fault_d;
        end
    end

    assign pc          = pc_q;
    assign inst_pc     = inst_pc_q;
    assign ir          = ir_q;
    assign alu_out     = alu_out_q;
    assign instr_count = instr_count_q;
    assign pc_fault    = pc_fault_q;

    assign Op    = ir_q[31:26];
    assign Funct = ir_q[5:0];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign imm   = ir_q[15:0];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Bench for pc_ir_unit: an arithmetic reference model checked every cycle, plus
// directed fetch/branch/jump/fault/wrap scenarios with literal expectations.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_Write, Branch, IR_Write, zero;
    logic [1:0]  PC_Src;
    logic [31:0] alu_result, reg_a, mem_rdata;

    logic [31:0] pc, inst_pc, ir, alu_out;
    logic [5:0]  Op, Funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] instr_count;
    logic        pc_fault;

    logic [31:0] pc4, inst_pc4, ir4, alu_out4;
    logic [5:0]  op4, funct4;
    logic [4:0]  rs4, rt4, rd4;
    logic [15:0] imm4;
    logic [3:0]  instr_count4;
    logic        pc_fault4;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_ir_unit dut (
        .clk(clk), .reset(reset), .PC_Write(PC_Write), .Branch(Branch), .PC_Src(PC_Src),
        .IR_Write(IR_Write), .zero(zero), .alu_result(alu_result), .reg_a(reg_a),
        .mem_rdata(mem_rdata), .pc(pc), .inst_pc(inst_pc), .ir(ir), .Op(Op), .Funct(Funct),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .alu_out(alu_out), .instr_count(instr_count),
        .pc_fault(pc_fault)
    );

    pc_ir_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .PC_Write(PC_Write), .Branch(Branch), .PC_Src(PC_Src),
        .IR_Write(IR_Write), .zero(zero), .alu_result(alu_result), .reg_a(reg_a),
        .mem_rdata(mem_rdata), .pc(pc4), .inst_pc(inst_pc4), .ir(ir4), .Op(op4), .Funct(funct4),
        .rs(rs4), .rt(rt4), .rd(rd4), .imm(imm4), .alu_out(alu_out4), .instr_count(instr_count4),
        .pc_fault(pc_fault4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of one clock edge, in plain arithmetic.
    longint unsigned m_pc, m_inst_pc, m_ir, m_alu_out, m_count;
    bit              m_fault;

    always @(posedge clk) begin
        longint unsigned target;
        longint unsigned old_pc;
        if (reset) begin
            m_pc = 64'h0040_0000; m_inst_pc = 0; m_ir = 0; m_alu_out = 0; m_count = 0; m_fault = 0;
        end else begin
            old_pc = m_pc;
            case (PC_Src)
                2'd0:    target = alu_result;
                2'd1:    target = m_alu_out;
                2'd2:    target = (m_pc / 64'h1000_0000) * 64'h1000_0000 + (m_ir % 64'h400_0000) * 4;
                default: target = reg_a;
            endcase
            if (PC_Write || (Branch && zero)) begin
                if (target % 4 != 0) m_fault = 1;
                else                 m_pc = target;
            end
            if (IR_Write) begin
                m_ir      = mem_rdata;
                m_inst_pc = old_pc;
                m_count   = (m_count + 1) % 64'h1_0000_0000;
            end
            m_alu_out = alu_result;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc",        pc,          m_pc);
            check("inst_pc",   inst_pc,     m_inst_pc);
            check("ir",        ir,          m_ir);
            check("Op",        Op,          m_ir / 64'h400_0000);
            check("Funct",     Funct,       m_ir % 64);
            check("rs",        rs,          (m_ir / 64'h20_0000) % 32);
            check("rt",        rt,          (m_ir / 64'h1_0000) % 32);
            check("rd",        rd,          (m_ir / 64'h800) % 32);
            check("imm",       imm,         m_ir % 64'h1_0000);
            check("alu_out",   alu_out,     m_alu_out);
            check("count",     instr_count, m_count);
            check("count4",    instr_count4, m_count % 16);
            check("pc_fault",  pc_fault,    m_fault);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PC_Write = 0; Branch = 0; IR_Write = 0; zero = 0; PC_Src = 2'd0;
    endtask

    initial begin
        reset = 1; idle();
        alu_result = 0; reg_a = 0; mem_rdata = 0;

        // Reset held two cycles with strobes toggling.
        PC_Write = 1; IR_Write = 1; alu_result = 32'h1234_5678; mem_rdata = 32'hFFFF_FFFF;
        cyc();
        chk_en = 1;
        PC_Write = 0; IR_Write = 0; Branch = 1; zero = 1;
        cyc();
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_ir", ir, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_fault", pc_fault, 0);

        // Fetch.
        reset = 0; idle();
        PC_Write = 1; IR_Write = 1; PC_Src = 2'd0;
        alu_result = 32'h0040_0004; mem_rdata = 32'h012A_4020;
        cyc();
        check("fetch_pc", pc, 32'h0040_0004);
        check("fetch_inst_pc", inst_pc, 32'h0040_0000);
        check("fetch_op", Op, 0);
        check("fetch_funct", Funct, 6'h20);
        check("fetch_rd", rd, 8);
        check("fetch_cnt", instr_count, 1);

        // Branch: target captured in alu_out, then not-taken and taken.
        idle(); alu_result = 32'h0040_0010;
        cyc();
        check("br_alu_out", alu_out, 32'h0040_0010);
        Branch = 1; PC_Src = 2'd1; zero = 0;
        cyc();
        check("br_not_taken", pc, 32'h0040_0004);
        zero = 1;
        cyc();
        check("br_taken", pc, 32'h0040_0010);

        // Move to 0x40000008 with J instruction in IR, then jump.
        idle(); PC_Write = 1; PC_Src = 2'd3; reg_a = 32'h4000_0008;
        IR_Write = 1; mem_rdata = 32'h0800_0100;
        cyc();
        check("jr_pc", pc, 32'h4000_0008);
        check("jr_ir", ir, 32'h0800_0100);
        idle(); PC_Write = 1; PC_Src = 2'd2;
        cyc();
        check("jump_pc", pc, 32'h4000_0400);

        // Misaligned JR, then aligned JR with sticky fault.
        idle(); PC_Write = 1; PC_Src = 2'd3; reg_a = 32'h0040_0006;
        cyc();
        check("mis_pc", pc, 32'h4000_0400);
        check("mis_fault", pc_fault, 1);
        reg_a = 32'h0040_0020;
        cyc();
        check("al_pc", pc, 32'h0040_0020);
        check("al_fault", pc_fault, 1);

        // Counter wrap on the 4-bit instance.
        idle(); reset = 1;
        cyc();
        reset = 0; IR_Write = 1;
        for (int i = 0; i < 15; i++) begin
            mem_rdata = $urandom;
            cyc();
        end
        check("cnt4_15", instr_count4, 15);
        cyc();
        check("cnt4_wrap", instr_count4, 0);
        check("cnt_16", instr_count, 16);

        // Reset beats a simultaneous PC update.
        idle(); reset = 1; PC_Write = 1; PC_Src = 2'd3; reg_a = 32'h1234_5678;
        cyc();
        check("rst_prio_pc", pc, 32'h0040_0000);
        check("rst_prio_fault", pc_fault, 0);
        reset = 0;

        // Random traffic, occasionally misaligned targets and resets.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            PC_Write   = $urandom_range(0, 2) == 0;
            Branch     = $urandom_range(0, 2) == 0;
            zero       = $urandom_range(0, 1);
            IR_Write   = $urandom_range(0, 1);
            PC_Src     = 2'($urandom_range(0, 3));
            alu_result = $urandom;
            reg_a      = $urandom;
            mem_rdata  = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                alu_result[1:0] = 2'b00;
                reg_a[1:0]      = 2'b00;
            end
            cyc();
        end

        idle(); reset = 0;
        cyc();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
